// File: rtl/pc_seq_pkg.sv
// Shared definitions for the next-PC sequencer: opcodes, FSM states, field widths.
package pc_seq_pkg;

    localparam int OP_W    = 6;
    localparam int IMM_W   = 26;
    localparam int IMM16_W = 16;

    localparam logic [OP_W-1:0] OP_J   = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE = 6'h05;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT_I  = 2'd1,
        BR_WAIT = 2'd2
    } pc_state_e;

    function automatic logic is_jump(input logic [OP_W-1:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

    function automatic logic is_branch(input logic [OP_W-1:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/bj_target_calc.sv
// Combinational target generator: sequential, J-format jump and PC-relative branch targets
// for the instruction fetched at pc_dec. All sums wrap modulo 2^ADDR_W.
module bj_target_calc
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_dec,
    input  logic [IMM_W-1:0]  imm26,
    output logic [ADDR_W-1:0] seq_tgt,
    output logic [ADDR_W-1:0] jump_tgt,
    output logic [ADDR_W-1:0] br_tgt
);

    logic [ADDR_W-1:0] br_off;

    always_comb begin
        seq_tgt  = pc_dec + ADDR_W'(4);
        // Jump keeps the upper region bits of the delay-slot address.
        jump_tgt = seq_tgt;
        jump_tgt[IMM_W+1:0] = {imm26, 2'b00};
        br_off   = {{(ADDR_W-IMM16_W-2){imm26[IMM16_W-1]}}, imm26[IMM16_W-1:0], 2'b00};
        br_tgt   = seq_tgt + br_off;
    end

endmodule

// File: rtl/pc_branch_sequencer.sv
// Next-PC controller: owns the PC, issues one fetch at a time, resolves jumps/branches.
// Build option DELAY_SLOT_EN enables a MIPS-style branch delay slot.
module pc_branch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_ready,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] pc,
    input  logic              instr_valid,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [IMM_W-1:0]  instr_imm,
    input  logic              cmp_valid,
    input  logic              cmp_taken,
    output logic              redirect,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_addr,
    output logic              wait_err,
    output pc_state_e         state_dbg
);

    localparam int WCNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_dec_q, pc_dec_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              redirect_q, redirect_d;
    logic              link_we_q, link_we_d;
    logic [ADDR_W-1:0] link_addr_q, link_addr_d;
    logic              wait_err_q, wait_err_d;
`ifdef DELAY_SLOT_EN
    logic              slot_pend_q, slot_pend_d;
`endif

    logic [ADDR_W-1:0] seq_tgt, jump_tgt, br_tgt;

    bj_target_calc #(.ADDR_W(ADDR_W)) u_tgt (
        .pc_dec   (pc_dec_q),
        .imm26    (instr_imm),
        .seq_tgt  (seq_tgt),
        .jump_tgt (jump_tgt),
        .br_tgt   (br_tgt)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_dec_d    = pc_dec_q;
        tgt_d       = tgt_q;
        wcnt_d      = wcnt_q;
        redirect_d  = 1'b0;
        link_we_d   = 1'b0;
        link_addr_d = link_addr_q;
        wait_err_d  = 1'b0;
`ifdef DELAY_SLOT_EN
        slot_pend_d = slot_pend_q;
`endif
        case (state_q)
            ISSUE: begin
                if (fetch_ready) begin
                    pc_dec_d = pc_q;
                    state_d  = WAIT_I;
                end
            end
            WAIT_I: begin
                if (instr_valid) begin
                    state_d = ISSUE;
`ifdef DELAY_SLOT_EN
                    // The slot instruction always completes the pending redirect.
                    if (slot_pend_q) begin
                        pc_d        = tgt_q;
                        redirect_d  = 1'b1;
                        slot_pend_d = 1'b0;
                    end else
`endif
                    if (is_jump(instr_op)) begin
`ifdef DELAY_SLOT_EN
                        tgt_d       = jump_tgt;
                        slot_pend_d = 1'b1;
                        pc_d        = seq_tgt;
`else
                        pc_d        = jump_tgt;
                        redirect_d  = 1'b1;
`endif
                        if (instr_op == OP_JAL) begin
                            link_we_d   = 1'b1;
                            link_addr_d = pc_dec_q + ADDR_W'(8);
                        end
                    end else if (is_branch(instr_op)) begin
                        tgt_d   = br_tgt;
                        wcnt_d  = '0;
                        state_d = BR_WAIT;
                    end else begin
                        pc_d = seq_tgt;
                    end
                end
            end
            BR_WAIT: begin
                if (cmp_valid && cmp_taken) begin
                    state_d = ISSUE;
`ifdef DELAY_SLOT_EN
                    slot_pend_d = 1'b1;
                    pc_d        = seq_tgt;
`else
                    pc_d        = tgt_q;
                    redirect_d  = 1'b1;
`endif
                end else if (cmp_valid) begin
                    state_d = ISSUE;
                    pc_d    = seq_tgt;
                end else if (wcnt_q == WCNT_W'(MAX_WAIT - 1)) begin
                    // Comparator never answered: fall through as not-taken.
                    state_d    = ISSUE;
                    pc_d       = seq_tgt;
                    wait_err_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ISSUE;
            pc_q        <= RESET_PC;
            pc_dec_q    <= '0;
            tgt_q       <= '0;
            wcnt_q      <= '0;
            redirect_q  <= 1'b0;
            link_we_q   <= 1'b0;
            link_addr_q <= '0;
            wait_err_q  <= 1'b0;
`ifdef DELAY_SLOT_EN
            slot_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_dec_q    <= pc_dec_d;
            tgt_q       <= tgt_d;
            wcnt_q      <= wcnt_d;
            redirect_q  <= redirect_d;
            link_we_q   <= link_we_d;
            link_addr_q <= link_addr_d;
            wait_err_q  <= wait_err_d;
`ifdef DELAY_SLOT_EN
            slot_pend_q <= slot_pend_d;
`endif
        end
    end

    assign fetch_valid = (state_q == ISSUE) && !rst;
    assign pc          = pc_q;
    assign redirect    = redirect_q;
    assign link_we     = link_we_q;
    assign link_addr   = link_addr_q;
    assign wait_err    = wait_err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Randomized bench for pc_branch_sequencer with an in-bench instruction-level model.
// Works for both builds (DELAY_SLOT_EN defined or not).
module tb_pc_branch_sequencer;
    import pc_seq_pkg::*;

    localparam int          MAX_WAIT = 4;
    localparam logic [31:0] RST_PC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        fetch_valid;
    logic [31:0] pc;
    logic        instr_valid = 1'b0;
    logic [5:0]  instr_op = '0;
    logic [25:0] instr_imm = '0;
    logic        cmp_valid = 1'b0;
    logic        cmp_taken = 1'b0;
    logic        redirect;
    logic        link_we;
    logic [31:0] link_addr;
    logic        wait_err;
    pc_state_e   state_dbg;

    pc_branch_sequencer #(.ADDR_W(32), .RESET_PC(RST_PC), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .pc(pc),
        .instr_valid(instr_valid), .instr_op(instr_op), .instr_imm(instr_imm),
        .cmp_valid(cmp_valid), .cmp_taken(cmp_taken), .redirect(redirect), .link_we(link_we),
        .link_addr(link_addr), .wait_err(wait_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Instruction-level model of what the outputs must show.
    logic [31:0] m_pc, m_laddr, m_tgt;
    logic        m_fv, m_redir, m_lwe, m_werr, m_slot;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("fetch_valid", 32'(fetch_valid), 32'(m_fv));
            check("pc", pc, m_pc);
            check("redirect", 32'(redirect), 32'(m_redir));
            check("link_we", 32'(link_we), 32'(m_lwe));
            check("link_addr", link_addr, m_laddr);
            check("wait_err", 32'(wait_err), 32'(m_werr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        m_redir = 1'b0;
        m_lwe   = 1'b0;
        m_werr  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fetch_ready = 1'b0;
        instr_valid = 1'b0;
        cmp_valid = 1'b0;
        m_pc = RST_PC; m_fv = 1'b0; m_laddr = '0; m_tgt = '0;
        m_redir = 1'b0; m_lwe = 1'b0; m_werr = 1'b0; m_slot = 1'b0;
        #1;
        chk_en = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        m_fv = 1'b1;
    endtask

    // Redirect to a non-sequential target, honouring the delay slot when built in.
    task automatic take_to(input logic [31:0] tgt, input logic [31:0] seq);
`ifdef DELAY_SLOT_EN
        m_tgt = tgt; m_slot = 1'b1; m_pc = seq;
`else
        m_pc = tgt; m_redir = 1'b1;
        if (seq == 32'hx) m_pc = tgt;
`endif
    endtask

    // cdelay: BR_WAIT cycle index where cmp_valid arrives (>= MAX_WAIT means never).
    // rst_at: BR_WAIT cycle index at which reset is asserted (-1 for none).
    task automatic run_instr(input logic [5:0] op, input logic [25:0] imm, input int stall,
                             input int idelay, input int cdelay, input bit taken, input int rst_at);
        logic [31:0] dec, seq, jmp, br;
        bit done;
        repeat (stall) begin
            fetch_ready = 1'b0;
            instr_valid = 1'($urandom_range(0, 1));
            instr_op = OP_J;
            cmp_valid = 1'($urandom_range(0, 1));
            step();
        end
        fetch_ready = 1'b1; instr_valid = 1'b0; cmp_valid = 1'b0;
        step();
        dec = m_pc; m_fv = 1'b0;
        repeat (idelay) begin
            fetch_ready = 1'($urandom_range(0, 1));
            instr_valid = 1'b0;
            cmp_valid = 1'($urandom_range(0, 1));
            cmp_taken = 1'b1;
            step();
        end
        fetch_ready = 1'b0;
        instr_valid = 1'b1; instr_op = op; instr_imm = imm;
        cmp_valid = 1'($urandom_range(0, 1)); cmp_taken = 1'b1;
        step();
        instr_valid = 1'b0; cmp_valid = 1'b0;
        seq = dec + 32'd4;
        jmp = {seq[31:28], imm, 2'b00};
        br  = seq + {{14{imm[15]}}, imm[15:0], 2'b00};
        if (m_slot) begin
            m_pc = m_tgt; m_redir = 1'b1; m_slot = 1'b0; m_fv = 1'b1;
        end else if (op == OP_J || op == OP_JAL) begin
            if (op == OP_JAL) begin
                m_lwe = 1'b1; m_laddr = dec + 32'd8;
            end
            take_to(jmp, seq);
            m_fv = 1'b1;
        end else if (op == OP_BEQ || op == OP_BNE) begin
            done = 1'b0;
            for (int w = 0; w < MAX_WAIT && !done; w++) begin
                if (w == rst_at) begin
                    do_reset();
                    return;
                end
                cmp_valid = (w == cdelay);
                cmp_taken = (w == cdelay) ? taken : 1'($urandom_range(0, 1));
                instr_valid = 1'($urandom_range(0, 1)); instr_op = OP_JAL;
                step();
                cmp_valid = 1'b0; instr_valid = 1'b0;
                if (w == cdelay) begin
                    done = 1'b1;
                    if (taken) take_to(br, seq);
                    else m_pc = seq;
                end else if (w == MAX_WAIT - 1) begin
                    done = 1'b1; m_werr = 1'b1; m_pc = seq;
                end
            end
            m_fv = 1'b1;
        end else begin
            m_pc = seq; m_fv = 1'b1;
        end
    endtask

    function automatic logic [5:0] rand_op();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return (r == 0) ? 6'h00 : 6'($urandom_range(6, 63));
        if (r == 4) return OP_J;
        if (r == 5) return OP_JAL;
        if (r < 8) return OP_BEQ;
        return OP_BNE;
    endfunction

    initial begin
        #2;
        do_reset();
        check("rst_pc", pc, 32'h100);
        check("rst_state", 32'(state_dbg), 32'(ISSUE));
`ifndef DELAY_SLOT_EN
        run_instr(6'h00, 26'h0, 1, 0, 0, 0, -1);
        check("seq1_pc", pc, 32'h104);
        run_instr(6'h08, 26'h123, 0, 1, 0, 0, -1);
        check("seq2_pc", pc, 32'h108);
        run_instr(6'h00, 26'h0, 0, 0, 0, 0, -1);
        run_instr(OP_J, 26'h010_0004, 0, 0, 0, 0, -1);
        check("j_pc", pc, 32'h0040_0010);
        run_instr(OP_JAL, 26'h000_0100, 0, 2, 0, 0, -1);
        check("jal_pc", pc, 32'h0000_0400);
        check("jal_redirect", 32'(redirect), 32'h1);
        check("jal_link_we", 32'(link_we), 32'h1);
        check("jal_link_addr", link_addr, 32'h0040_0018);
        run_instr(OP_J, 26'h80, 0, 0, 0, 0, -1);
        check("j200_pc", pc, 32'h200);
        run_instr(OP_BEQ, 26'hFFFE, 0, 0, 2, 1, -1);
        check("beq_t_pc", pc, 32'h1FC);
        check("beq_t_redirect", 32'(redirect), 32'h1);
        run_instr(OP_J, 26'h80, 0, 0, 0, 0, -1);
        run_instr(OP_BEQ, 26'hFFFE, 0, 0, 2, 0, -1);
        check("beq_nt_pc", pc, 32'h204);
        check("beq_nt_redirect", 32'(redirect), 32'h0);
        run_instr(OP_BNE, 26'h10, 0, 0, MAX_WAIT, 0, -1);
        check("bne_to_pc", pc, 32'h208);
        check("bne_to_err", 32'(wait_err), 32'h1);
        run_instr(OP_BEQ, 26'hFF7C, 0, 0, 0, 1, -1);
        check("neg_br_pc", pc, 32'hFFFF_FFFC);
        run_instr(6'h00, 26'h0, 0, 0, 0, 0, -1);
        check("wrap_pc", pc, 32'h0);
        run_instr(OP_BEQ, 26'h4, 0, 0, MAX_WAIT, 0, 1);
        check("midbr_rst_pc", pc, 32'h100);
        check("midbr_rst_state", 32'(state_dbg), 32'(ISSUE));
        check("midbr_rst_redirect", 32'(redirect), 32'h0);
`else
        run_instr(OP_J, 26'hC0, 0, 0, 0, 0, -1);
        check("ds_j_slot_pc", pc, 32'h104);
        run_instr(6'h00, 26'h0, 0, 0, 0, 0, -1);
        check("ds_j_tgt_pc", pc, 32'h300);
        check("ds_j_tgt_redirect", 32'(redirect), 32'h1);
        run_instr(OP_J, 26'h80, 0, 1, 0, 0, -1);
        check("ds_slot_pc", pc, 32'h304);
        check("ds_slot_redirect", 32'(redirect), 32'h0);
        run_instr(OP_BEQ, 26'h0, 0, 0, 0, 1, -1);
        check("ds_redir_pc", pc, 32'h200);
        check("ds_redir_redirect", 32'(redirect), 32'h1);
`endif
        for (int i = 0; i < 250; i++) begin
            int rst_at;
            rst_at = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, MAX_WAIT - 1)) : -1;
            run_instr(rand_op(), 26'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(0, MAX_WAIT), 1'($urandom_range(0, 1)), rst_at);
        end
        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_branch_sequencer.md
Name: pc_branch_sequencer

Overview:
- Next-PC controller for the single-cycle-fetch CPU. It owns the PC register and issues fetches to instruction memory with one fetch outstanding at a time.
- It decodes control-flow opcodes and computes jump and branch targets through a target sub-module.
- For conditional branches it waits on the comparator's taken bit (bra_out_bit equivalent).
- It sequences redirects, JAL link writes, comparator timeout and an optional MIPS delay slot.

Parameters:
- ADDR_W, 32, PC/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 15, max BR_WAIT cycles without cmp_valid before timeout (must be >=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_ready  in  1  instruction memory accepts pc this cycle.
- fetch_valid  out  1  pc is a valid fetch request.
- pc  out  ADDR_W  current fetch address.
- instr_valid  in  1  instruction for the last accepted fetch is present.
- instr_op  in  6  instruction bits [31:26].
- instr_imm  in  26  instruction bits [25:0].
- cmp_valid  in  1  comparator result valid.
- cmp_taken  in  1  branch condition true (qualified by cmp_valid).
- redirect  out  1  one-cycle pulse when pc is loaded with a non-sequential target.
- link_we  out  1  one-cycle pulse to write link_addr to $31 (JAL).
- link_addr  out  ADDR_W  return address for JAL.
- wait_err  out  1  one-cycle pulse on comparator timeout.

Behaviour:
- Reset (async, any state):
  - state=ISSUE, pc=RESET_PC, pc_dec=0, tgt_q=0, wcnt=0, slot_pend=0.
  - redirect=0, link_we=0, link_addr=0, wait_err=0.
  - fetch_valid is forced 0 while rst=1.
  - Reset mid-branch discards all pending state.
- Opcodes: J=6'h02, JAL=6'h03, BEQ=6'h04, BNE=6'h05; all others are sequential.
- Targets (all arithmetic mod 2^ADDR_W, wrap allowed, no flag):
  - seq = pc_dec+4.
  - jump = {seq[31:28], imm[25:0], 2'b00}.
  - branch = seq + (sign_ext(imm[15:0])<<2).
- ISSUE:
  - fetch_valid=1.
  - On fetch_ready: pc_dec<=pc, go to WAIT_I.
  - pc is held stable until accepted.
- WAIT_I: fetch_valid=0; wait for instr_valid. On instr_valid:
  - Sequential op: pc<=seq, go to ISSUE.
  - J/JAL: pc<=jump, redirect=1, go to ISSUE. JAL also pulses link_we with link_addr<=pc_dec+8.
  - BEQ/BNE: tgt_q<=branch, wcnt<=0, go to BR_WAIT.
- BR_WAIT:
  - fetch_valid=0.
  - cmp_valid and cmp_taken: pc<=tgt_q, redirect=1, go to ISSUE.
  - cmp_valid and not cmp_taken: pc<=seq, go to ISSUE.
  - No cmp_valid: wcnt++. At wcnt==MAX_WAIT-1: wait_err=1, treat as not-taken.
- Ignored inputs:
  - cmp_valid is sampled only in BR_WAIT; a cmp_valid in the decode cycle is ignored.
  - instr_valid outside WAIT_I is ignored.
- Latency: sequential instruction needs ≥2 cycles (issue, return); branch needs ≥3.
- Pulses are registered and never last more than one cycle.

Optional Feature:
- Macro DELAY_SLOT_EN.
- Defined:
  - A taken branch or any J/JAL loads tgt_q, sets slot_pend, and sets pc<=seq (no redirect yet).
  - When the slot instruction returns in WAIT_I with slot_pend=1: pc<=tgt_q, redirect=1, slot_pend<=0.
  - Control opcodes in the slot are treated as sequential.
  - JAL link_addr is pc_dec+8 in both builds.
- Undefined: no slot, behaviour as above, and slot_pend logic is absent.

Decomposition:
- Package pc_seq_pkg: opcode constants (OP_J, OP_JAL, OP_BEQ, OP_BNE), state encoding (ISSUE, WAIT_I, BR_WAIT), instruction-field width constants.
- Sub-module bj_target_calc: combinational; inputs pc_dec and imm26; outputs seq, jump and branch targets.

Test Plan:
- Reset with RESET_PC=0x100, then three sequential ops with fetch_ready=1 → pc goes 0x100, 0x104, 0x108. fetch_valid=0 during rst and in every WAIT_I cycle.
- JAL at pc 0x0040_0010 with imm26=0x0000100 → pc=0x0000_0400, redirect pulse, link_we pulse, link_addr=0x0040_0018.
- BEQ at 0x200 with imm16=0xFFFE, cmp_valid after 3 cycles with taken=1 → pc=0x1FC and redirect. Same with taken=0 → pc=0x204, no redirect.
- BNE, cmp_valid never asserted, MAX_WAIT=4 → wait_err pulse in the 4th BR_WAIT cycle, pc=seq.
- pc=0xFFFF_FFFC sequential → pc wraps to 0x0. Assert rst while in BR_WAIT → pc=RESET_PC, state ISSUE, no pulses.
- DELAY_SLOT_EN, J at 0x300 with imm26=0x80 → next fetch 0x304, then 0x200 with redirect after the slot returns.
